// File: rtl/brick_pkg.sv
// Shared constants, colours and mover state encoding for the brick game datapath.
package brick_pkg;

    localparam int unsigned DEF_X_MAX = 160;
    localparam int unsigned DEF_Y_MAX = 120;
    localparam int unsigned COLOUR_W  = 3;
    localparam int unsigned COORD_W   = 10;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StErase,
        StMove,
        StSettle,
        StDraw
    } mover_state_e;

    // One axis step, clamped so the position lands exactly on 0 or lim.
    // Arithmetic is one bit wider than a coordinate so the increment cannot wrap.
    function automatic logic [COORD_W-1:0] step_axis(
        input logic [COORD_W-1:0] pos,
        input logic               up,
        input logic [COORD_W:0]   step,
        input logic [COORD_W:0]   lim
    );
        logic [COORD_W:0] wide;
        wide = {1'b0, pos};
        if (up) begin
            return (wide + step > lim) ? COORD_W'(lim) : COORD_W'(wide + step);
        end
        return (wide < step) ? '0 : COORD_W'(wide - step);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Frame tick generator: counts enabled clocks and pulses once every TICK_DIV cycles.
module tick_divider #(
    parameter int unsigned TICK_DIV = 833334
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned   CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Tick at the wrap; counter is held at zero while the game is stopped.
    always_comb begin
        tick  = enable && (cnt_q == CntLast);
        cnt_d = cnt_q + CntW'(1);
        if (!enable || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ball_mover.sv
// Ball position owner: steps the ball once per frame tick and erases/redraws the
// SIZE x SIZE square one pixel at a time through a req/ack plot interface.
module ball_mover
    import brick_pkg::*;
#(
    parameter int unsigned          X_MAX       = DEF_X_MAX,
    parameter int unsigned          Y_MAX       = DEF_Y_MAX,
    parameter int unsigned          SIZE        = 4,
    parameter int unsigned          STEP        = 1,
    parameter int unsigned          TICK_DIV    = 833334,
    parameter int unsigned          X_INIT      = 78,
    parameter int unsigned          Y_INIT      = 58,
    parameter logic [COLOUR_W-1:0]  BALL_COLOUR = WHITE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                x_du,
    input  logic                y_du,
    output logic [COORD_W-1:0]  x,
    output logic [COORD_W-1:0]  y,
    output logic                draw_req,
    output logic [COORD_W-1:0]  draw_x,
    output logic [COORD_W-1:0]  draw_y,
    output logic [COLOUR_W-1:0] draw_colour,
    input  logic                draw_ack,
    output logic                busy
);

    localparam int unsigned        PixW    = 4;
    localparam logic [PixW-1:0]    PixLast = PixW'(SIZE - 1);
    localparam logic [COORD_W:0]   StepW   = (COORD_W + 1)'(STEP);
    localparam logic [COORD_W:0]   XLim    = (COORD_W + 1)'(X_MAX - SIZE);
    localparam logic [COORD_W:0]   YLim    = (COORD_W + 1)'(Y_MAX - SIZE);

    mover_state_e         state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [PixW-1:0]      px_q, px_d, py_q, py_d;
    logic                 settle_q, settle_d;
    logic                 pending_q, pending_d;
    logic                 draw_req_q, draw_req_d;
    logic [COORD_W-1:0]   draw_x_q, draw_x_d, draw_y_q, draw_y_d;
    logic [COLOUR_W-1:0]  draw_colour_q, draw_colour_d;
    logic                 tick;
    logic                 accept;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    // Sequencer: pending capture, pixel walk, move and settle, plus registered plot outputs.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        px_d          = px_q;
        py_d          = py_q;
        settle_d      = settle_q;
        pending_d     = pending_q;
        draw_x_d      = draw_x_q;
        draw_y_d      = draw_y_q;
        draw_colour_d = draw_colour_q;
        draw_req_d    = 1'b0;
        accept        = draw_req_q && draw_ack;

        // A tick while already pending is simply absorbed.
        if (tick) begin
            pending_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (pending_q) begin
                    state_d   = StErase;
                    pending_d = 1'b0;
                end
            end
            StErase, StDraw: begin
                if (accept) begin
                    if (px_q == PixLast) begin
                        px_d = '0;
                        if (py_q == PixLast) begin
                            py_d    = '0;
                            state_d = (state_q == StErase) ? StMove : StIdle;
                        end else begin
                            py_d = py_q + PixW'(1);
                        end
                    end else begin
                        px_d = px_q + PixW'(1);
                    end
                end
            end
            StMove: begin
                x_d      = step_axis(x_q, x_du, StepW, XLim);
                y_d      = step_axis(y_q, y_du, StepW, YLim);
                settle_d = 1'b0;
                state_d  = StSettle;
            end
            StSettle: begin
                // Two cycles so the direction logic sees the new position first.
                if (settle_q) begin
                    settle_d = 1'b0;
                    state_d  = StDraw;
                end else begin
                    settle_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Plot outputs are registered from the next state so ack never reaches req directly.
        if (state_d == StErase || state_d == StDraw) begin
            draw_req_d    = 1'b1;
            draw_x_d      = x_q + COORD_W'(px_d);
            draw_y_d      = y_q + COORD_W'(py_d);
            draw_colour_d = (state_d == StErase) ? BLACK : BALL_COLOUR;
        end
    end

    // State and datapath registers; reset starts a full redraw at the home position.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StDraw;
            x_q           <= COORD_W'(X_INIT);
            y_q           <= COORD_W'(Y_INIT);
            px_q          <= '0;
            py_q          <= '0;
            settle_q      <= 1'b0;
            pending_q     <= 1'b0;
            draw_req_q    <= 1'b0;
            draw_x_q      <= '0;
            draw_y_q      <= '0;
            draw_colour_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            px_q          <= px_d;
            py_q          <= py_d;
            settle_q      <= settle_d;
            pending_q     <= pending_d;
            draw_req_q    <= draw_req_d;
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            draw_colour_q <= draw_colour_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign draw_req    = draw_req_q;
    assign draw_x      = draw_x_q;
    assign draw_y      = draw_y_q;
    assign draw_colour = draw_colour_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ball_mover.sv
// Self-checking bench for ball_mover: a pixel-stream scoreboard plus directed and random phases.
module tb_ball_mover;

    localparam int unsigned TICK_DIV = 8;
    localparam int unsigned SIZE     = 2;
    localparam int unsigned STEP     = 3;
    localparam int unsigned X_MAX    = 160;
    localparam int unsigned Y_MAX    = 120;
    localparam int unsigned X_INIT   = 78;
    localparam int unsigned Y_INIT   = 58;
    localparam int          XL       = X_MAX - SIZE;
    localparam int          YL       = Y_MAX - SIZE;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset, enable, x_du, y_du, draw_ack;
    logic [9:0] x, y, draw_x, draw_y;
    logic [2:0] draw_colour;
    logic       draw_req, busy;

    always #5 clk = ~clk;

    ball_mover #(
        .X_MAX       (X_MAX),
        .Y_MAX       (Y_MAX),
        .SIZE        (SIZE),
        .STEP        (STEP),
        .TICK_DIV    (TICK_DIV),
        .X_INIT      (X_INIT),
        .Y_INIT      (Y_INIT),
        .BALL_COLOUR (3'b111)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .x_du        (x_du),
        .y_du        (y_du),
        .x           (x),
        .y           (y),
        .draw_req    (draw_req),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_colour (draw_colour),
        .draw_ack    (draw_ack),
        .busy        (busy)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_moves  = 0;
    int          n_pixels = 0;
    int          ack_mode = 0;   // 0: always ack, 1: random, 2: hold off
    int unsigned ack_pct  = 70;
    int          mx, my;
    pix_t        exp_q[$];
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic        prev_busy = 1'b0;
    logic [9:0]  prev_x, prev_y;
    logic [2:0]  prev_c;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    function automatic int next_pos(input int p, input logic up, input int lim);
        if (up) return (p + int'(STEP) > lim) ? lim : p + int'(STEP);
        return (p < int'(STEP)) ? 0 : p - int'(STEP);
    endfunction

    task automatic push_square(input int c);
        for (int py = 0; py < int'(SIZE); py++)
            for (int px = 0; px < int'(SIZE); px++)
                exp_q.push_back('{mx + px, my + py, c});
    endtask

    task automatic model_reset();
        exp_q.delete();
        mx = X_INIT;
        my = Y_INIT;
        push_square(7);
    endtask

    task automatic monitor();
        pix_t e;
        if (prev_req && !prev_ack) begin
            check("hold_req", draw_req, 1);
            check("hold_x", draw_x, prev_x);
            check("hold_y", draw_y, prev_y);
            check("hold_colour", draw_colour, prev_c);
        end
        if (draw_req && draw_ack) begin
            if (exp_q.size() == 0) begin
                if (draw_colour == 3'd0) begin
                    // New frame step: erase old square, move, draw new square.
                    push_square(0);
                    mx = next_pos(mx, x_du, XL);
                    my = next_pos(my, y_du, YL);
                    push_square(7);
                    n_moves++;
                end else begin
                    check("unexpected_draw_colour", draw_colour, 0);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pix_x", draw_x, e.x);
                check("pix_y", draw_y, e.y);
                check("pix_colour", draw_colour, e.c);
                n_pixels++;
            end
        end
        if (prev_busy && !busy) begin
            check("idle_x", x, mx);
            check("idle_y", y, my);
            check("idle_queue", exp_q.size(), 0);
        end
        // Bench plays the direction logic: bounce at the walls, only while idle.
        if (!busy) begin
            if (x == 10'd0) x_du = 1'b1;
            else if (int'(x) == XL) x_du = 1'b0;
            if (y == 10'd0) y_du = 1'b1;
            else if (int'(y) == YL) y_du = 1'b0;
        end
        prev_req  = draw_req;
        prev_ack  = draw_ack;
        prev_busy = busy;
        prev_x    = draw_x;
        prev_y    = draw_y;
        prev_c    = draw_colour;
    endtask

    task automatic cycle();
        @(negedge clk);
        case (ack_mode)
            0:       draw_ack = 1'b1;
            1:       draw_ack = ($urandom_range(99) < ack_pct);
            default: draw_ack = 1'b0;
        endcase
        if (reset) begin
            prev_req  = 1'b0;
            prev_ack  = 1'b0;
            prev_busy = busy;
        end else begin
            monitor();
        end
    endtask

    task automatic pulse_ticks(input int n);
        enable = 1'b1;
        repeat (n * int'(TICK_DIV)) cycle();
        enable = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int q = 0;
        int n = 0;
        while (q < 20 && n < budget) begin
            cycle();
            n++;
            q = busy ? 0 : q + 1;
        end
        if (q < 20) check("timeout_quiet", 0, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        reset    = 1'b1;
        enable   = 1'b0;
        x_du     = 1'b1;
        y_du     = 1'b0;
        draw_ack = 1'b0;
        model_reset();

        // Reset values.
        repeat (2) cycle();
        check("rst_req", draw_req, 0);
        check("rst_x", x, X_INIT);
        check("rst_y", y, Y_INIT);
        check("rst_draw_x", draw_x, 0);
        check("rst_draw_y", draw_y, 0);
        check("rst_colour", draw_colour, 0);
        check("rst_busy", busy, 1);
        reset = 1'b0;

        // Boot redraw with ack tied high.
        ack_mode = 0;
        wait_quiet(200);
        check("boot_pixels", n_pixels, 4);
        check("boot_busy", busy, 0);

        // Single tick: erase, step (+x, -y), redraw.
        base = n_moves;
        pulse_ticks(1);
        wait_quiet(200);
        check("one_move", n_moves - base, 1);
        check("move_x", x, 81);
        check("move_y", y, 55);
        check("move_pixels", n_pixels, 12);

        // Ack withheld mid-erase: request and coordinates must hold.
        ack_mode = 2;
        pulse_ticks(1);
        n = 0;
        while (!(draw_req && draw_colour == 3'd0) && n < 50) begin
            cycle();
            n++;
        end
        check("erase_start_req", draw_req, 1);
        repeat (10) cycle();
        check("held_req", draw_req, 1);
        check("held_x", draw_x, 81);
        check("held_y", draw_y, 55);
        ack_mode = 0;
        cycle();
        ack_mode = 2;
        cycle();
        check("next_pix_x", draw_x, 82);
        check("next_pix_y", draw_y, 55);
        ack_mode = 0;
        wait_quiet(200);
        check("hold_move_x", x, 84);
        check("hold_move_y", y, 52);

        // Three ticks inside one busy sequence collapse into one extra move.
        base = n_moves;
        ack_mode = 2;
        pulse_ticks(1);
        pulse_ticks(3);
        ack_mode = 0;
        wait_quiet(400);
        check("dropped_ticks", n_moves - base, 2);

        // Reset while a DRAW request is outstanding.
        ack_mode = 0;
        pulse_ticks(1);
        n = 0;
        while (!(draw_req && draw_colour == 3'd7) && n < 100) begin
            cycle();
            n++;
        end
        check("draw_seen", draw_colour, 7);
        reset = 1'b1;
        model_reset();
        cycle();
        check("mid_rst_req", draw_req, 0);
        check("mid_rst_x", x, X_INIT);
        check("mid_rst_y", y, Y_INIT);
        check("mid_rst_busy", busy, 1);
        reset = 1'b0;
        base = n_pixels;
        wait_quiet(200);
        check("redraw_pixels", n_pixels - base, 4);

        // Random ack and enable, bouncing off all four walls.
        ack_mode = 1;
        base = n_moves;
        n = 0;
        while (n_moves - base < 150 && n < 30000) begin
            enable = ($urandom_range(99) < 90);
            cycle();
            n++;
        end
        check("random_moves_done", int'(n_moves - base >= 150), 1);
        enable = 1'b0;
        wait_quiet(500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
